// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one I2C master between two requesters with stall/abort handling
module i2c_master_arbiter #(
    parameter int WD_CYCLES    = 4096,
    parameter int START_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       req0_rw,
    input  logic       req1_rw,
    input  logic [5:0] req0_nbytes,
    input  logic [5:0] req1_nbytes,
    input  logic [6:0] req0_saddr,
    input  logic [6:0] req1_saddr,
    input  logic [7:0] req0_regaddr,
    input  logic [7:0] req1_regaddr,
    input  logic [7:0] req0_wdata,
    input  logic [7:0] req1_wdata,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic [1:0] own_ready,
    output logic       own_ack,
    output logic [7:0] rdata,
    output logic       m_go,
    output logic       m_stop,
    output logic       m_rw,
    output logic [5:0] m_nbytes,
    output logic [6:0] m_saddr,
    output logic [7:0] m_regaddr,
    output logic [7:0] m_wdata,
    input  logic       m_done,
    input  logic       m_ready,
    input  logic       m_ack,
    input  logic [7:0] m_readdata
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] GO    = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;
    localparam int WW = $clog2(WD_CYCLES + 1);
    localparam int SW = $clog2(START_CYCLES + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(WD_CYCLES - 1);
    localparam logic [SW-1:0] ST_MAX = SW'(START_CYCLES - 1);

    logic [2:0]    state;
    logic          last;
    logic          prev_ready;
    logic [WW-1:0] wd_cnt;
    logic [SW-1:0] start_cnt;
    logic          win;
    logic          owner_req;
    logic          stall;

    // Ties go to whoever was not served last
    assign win       = (req[0] & req[1]) ? ~last : req[1];
    assign owner_req = |(req & gnt);
    assign stall     = (wd_cnt == WD_MAX) && (m_ready == prev_ready);
    assign own_ready = gnt & {2{m_ready}};
    assign own_ack   = |gnt & m_ack;
    assign rdata     = m_readdata;
    assign m_regaddr = gnt[0] ? req0_regaddr : gnt[1] ? req1_regaddr : 8'd0;
    assign m_wdata   = gnt[0] ? req0_wdata : gnt[1] ? req1_wdata : 8'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last       <= 1'b1;
            gnt        <= '0;
            done       <= '0;
            err        <= '0;
            m_go       <= 1'b0;
            m_stop     <= 1'b0;
            m_rw       <= 1'b0;
            m_nbytes   <= '0;
            m_saddr    <= '0;
            wd_cnt     <= '0;
            start_cnt  <= '0;
            prev_ready <= 1'b0;
        end else begin
            m_go       <= 1'b0;
            m_stop     <= 1'b0;
            done       <= '0;
            err        <= '0;
            prev_ready <= m_ready;
            case (state)
                IDLE: if (m_done && |req) begin
                    gnt      <= win ? 2'b10 : 2'b01;
                    last     <= win;
                    m_rw     <= win ? req1_rw : req0_rw;
                    m_nbytes <= win ? req1_nbytes : req0_nbytes;
                    m_saddr  <= win ? req1_saddr : req0_saddr;
                    state    <= GO;
                end
                GO: begin
                    m_go      <= 1'b1;
                    start_cnt <= '0;
                    state     <= START;
                end
                START: if (!m_done) begin
                    wd_cnt <= '0;
                    state  <= RUN;
                end else if (start_cnt == ST_MAX) begin
                    err   <= gnt;
                    gnt   <= '0;
                    state <= IDLE;
                end else begin
                    start_cnt <= start_cnt + 1'b1;
                end
                RUN: if (m_done) begin
                    done  <= gnt;
                    gnt   <= '0;
                    state <= IDLE;
                end else if (!owner_req || stall) begin
                    m_stop <= 1'b1;
                    state  <= DRAIN;
                end else begin
                    wd_cnt <= (m_ready != prev_ready) ? '0 : wd_cnt + 1'b1;
                end
                DRAIN: if (m_done) begin
                    err   <= gnt;
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
- Shares one I2C master engine between two transaction controllers: req 0 is the menu/RAM mirror controller, req 1 is the auxiliary poller.
- Arbitrates round-robin and latches the winning transaction's header (rw, slave address, byte count).
- Pulses the master's go and passes the per-byte handshake through to the owner only.
- Aborts a transaction with a stop if the owner withdraws its request or the master stalls past a watchdog limit.

Parameters:
- WD_CYCLES, 4096, stall limit in clk cycles while in RUN with no master_ready edge.
- START_CYCLES, 16, max cycles allowed between go and master_done falling.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  2  transaction request per requester; level, held until done/err
- req0_rw, req1_rw  in  1  0=write, 1=read
- req0_nbytes, req1_nbytes  in  6  byte count
- req0_saddr, req1_saddr  in  7  slave address
- req0_regaddr, req1_regaddr  in  8  register address, live
- req0_wdata, req1_wdata  in  8  write byte, live
- gnt  out  2  one-hot ownership
- done  out  2  one-cycle completion pulse to owner
- err  out  2  one-cycle abort/timeout pulse to owner
- own_ready  out  2  master_ready gated to owner
- own_ack  out  1  master_ack while granted, else 0
- rdata  out  8  master_readdata, ungated
- m_go  out  1  one-cycle start pulse to master
- m_stop  out  1  one-cycle stop pulse to master
- m_rw  out  1  latched header
- m_nbytes  out  6  latched header
- m_saddr  out  7  latched header
- m_regaddr  out  8  live mux of owner, 0 when no grant
- m_wdata  out  8  live mux of owner, 0 when no grant
- m_done  in  1  master idle
- m_ready  in  1  per-byte ready
- m_ack  in  1  slave ACK
- m_readdata  in  8  read byte

Behaviour:
- Reset state:
  - All outputs 0; state IDLE.
  - last-served pointer = 1, so req 0 wins the first tie.
  - Counters cleared.
  - Reset mid-transaction drops go/stop immediately and does not emit a stop; the master is reset by the same line.
- IDLE:
  - Waits for m_done=1 and req!=0.
  - Winner is the single requester, or on a tie the one not last served.
  - Latches rw/nbytes/saddr from the winner, sets gnt one-hot and updates the pointer, then goes to GO.
  - If m_done=0, no grant is issued.
- GO:
  - m_go=1 for exactly one cycle, in the cycle after the grant registers.
  - Start counter cleared; go to START.
- START:
  - On m_done=0, go to RUN.
  - If the counter reaches START_CYCLES first: err[owner] pulse, gnt cleared, go to IDLE (no stop issued).
- RUN:
  - Watchdog restarts on any m_ready transition.
  - On m_done rising (0 then 1): done[owner] pulse, gnt cleared, go to IDLE; the next grant comes no earlier than the following cycle.
  - If req[owner] falls: m_stop pulse 1 cycle, go to DRAIN, and record an abort.
  - If the watchdog reaches WD_CYCLES: m_stop pulse, go to DRAIN, and record a timeout.
  - Completion wins over a same-cycle req drop.
- DRAIN:
  - Waits for m_done=1, then pulses err[owner], clears gnt, goes to IDLE.
  - The err pulse is issued even if the owner has already dropped req.
- m_nbytes of 0 is passed through unchanged; the arbiter does not count bytes.
- own_ready/own_ack are combinational gates of the master inputs by registered gnt. Header outputs hold their last value after release.
- Non-owner req changes never affect an active transaction.

Test Plan:
- Single request: req=01, saddr=0x42, rw=0, nbytes=32, m_done=1.
  - Response: gnt=01 next cycle, m_go one cycle later.
  - Model drops m_done and raises it after 32 m_ready pulses: done[0] one-cycle pulse, gnt=00.
- Tie fairness: req=11 held continuously through three transactions.
  - Response: grants ordered 0,1,0; m_saddr switches between each requester's address.
- Abort: req1 granted, drops req at the 5th m_ready.
  - Response: m_stop one pulse next cycle; err[1] pulses once the model returns m_done=1; done[1] never asserted.
- Start timeout: model keeps m_done=1 after go.
  - Response: err pulse at cycle 16 after m_go, gnt=00, m_stop never asserted.
- Watchdog: WD_CYCLES set to 64; m_ready frozen in RUN.
  - Response: m_stop at cycle 64, then err after m_done=1.
- Gating and reset: while req0 is owner, toggle req1_wdata.
  - Response: m_wdata tracks only req0_wdata; own_ready[1] stays 0.
  - Then assert reset mid-RUN: all outputs 0 next edge, next tie grants req0.
